// File: rtl/modexp_lut_client.sv
// Sequential modular exponentiator: MSB-first square-and-multiply.
// All reductions go through an external one-cycle registered remainder table.
module modexp_lut_client #(
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       base,
    input  logic [EXP_W-1:0] exp,
    input  logic [5:0]       modulus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [5:0]       result,
    output logic [11:0]      lut_val,
    output logic [5:0]       lut_div,
    input  logic [5:0]       lut_rem,
    output logic [2:0]       dbg_state
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(EXP_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RB_ISS = 3'd1,
        RB_WT  = 3'd2,
        SQ_ISS = 3'd3,
        SQ_WT  = 3'd4,
        MU_ISS = 3'd5,
        MU_WT  = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t           state_q;
    logic [EXP_W-1:0] exp_q;
    logic [5:0]       base_q;
    logic [5:0]       acc_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [5:0]       result_q;
    logic [11:0]      lut_val_q;
    logic [5:0]       lut_div_q;

    // 6x6 product, always fits the 12-bit table value field.
    function automatic logic [11:0] mul6(input logic [5:0] a, input logic [5:0] b);
        return {6'b0, a} * {6'b0, b};
    endfunction

    // The table address is registered here, so each *_ISS value is loaded on
    // the transition into that state, using lut_rem when the operand is the
    // accumulator being updated in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            exp_q     <= '0;
            base_q    <= '0;
            acc_q     <= '0;
            bit_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
            lut_val_q <= '0;
            lut_div_q <= '0;
        end else begin
            done_q    <= 1'b0;
            lut_val_q <= '0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        exp_q     <= exp;
                        lut_div_q <= modulus;
                        acc_q     <= 6'd1;
                        bit_idx_q <= TOP_IDX;
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        if (modulus == 6'd0) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= '0;
                            err_q    <= 1'b1;
                        end else begin
                            state_q   <= RB_ISS;
                            lut_val_q <= {6'b0, base};
                        end
                    end
                end
                RB_ISS: state_q <= RB_WT;
                RB_WT: begin
                    base_q    <= lut_rem;
                    state_q   <= SQ_ISS;
                    lut_val_q <= mul6(acc_q, acc_q);
                end
                SQ_ISS: state_q <= SQ_WT;
                SQ_WT: begin
                    acc_q <= lut_rem;
                    if (exp_q[bit_idx_q]) begin
                        state_q   <= MU_ISS;
                        lut_val_q <= mul6(lut_rem, base_q);
                    end else if (bit_idx_q == '0) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        result_q <= lut_rem;
                    end else begin
                        bit_idx_q <= bit_idx_q - 1'b1;
                        state_q   <= SQ_ISS;
                        lut_val_q <= mul6(lut_rem, lut_rem);
                    end
                end
                MU_ISS: state_q <= MU_WT;
                MU_WT: begin
                    acc_q <= lut_rem;
                    if (bit_idx_q == '0) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        result_q <= lut_rem;
                    end else begin
                        bit_idx_q <= bit_idx_q - 1'b1;
                        state_q   <= SQ_ISS;
                        lut_val_q <= mul6(lut_rem, lut_rem);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign result    = result_q;
    assign lut_val   = lut_val_q;
    assign lut_div   = lut_div_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_modexp_lut_client.sv
// Bench for modexp_lut_client with a behavioural remainder table as responder.
module tb_modexp_lut_client;

    localparam int EXP_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [5:0]       base = '0;
    logic [EXP_W-1:0] exp_v = '0;
    logic [5:0]       modulus = '0;
    logic             busy, done, err;
    logic [5:0]       result;
    logic [11:0]      lut_val;
    logic [5:0]       lut_div;
    logic [5:0]       lut_rem = '0;
    logic [2:0]       dbg_state;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];

    modexp_lut_client #(.EXP_W(EXP_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exp(exp_v),
        .modulus(modulus), .busy(busy), .done(done), .err(err), .result(result),
        .lut_val(lut_val), .lut_div(lut_div), .lut_rem(lut_rem), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Remainder table: one-cycle registered read, divide-by-zero reads as 0.
    always @(posedge clk) begin
        if (lut_div == 6'd0) lut_rem <= 6'd0;
        else lut_rem <= 6'(lut_val % {6'b0, lut_div});
    end

    // Reference: base multiplied in exp times, reduced each step.
    function automatic int ref_modexp(input int b, input int e, input int m);
        int r;
        if (m == 0) return 0;
        r = 1 % m;
        for (int i = 0; i < e; i++) r = (r * b) % m;
        return r;
    endfunction

    function automatic int ref_latency(input logic [EXP_W-1:0] e, input int m);
        if (m == 0) return 1;
        return 3 + 2 * EXP_W + 2 * $countones(e);
    endfunction

    // Entered and left at #1 after a rising edge with the DUT idle; returns
    // in the cycle after the done pulse.
    task automatic do_op(input logic [5:0] b, input logic [EXP_W-1:0] e, input logic [5:0] m,
                         output int lat, output logic [5:0] res, output logic er,
                         output int busy_bad);
        base = b; exp_v = e; modulus = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; res = '0; er = 1'b0; busy_bad = 0;
        for (int n = 1; n <= 200; n++) begin
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                lat = n; res = result; er = err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, result, lut_val, lut_div} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b result=%0d lut_val=%0d lut_div=%0d expected all 0",
                     busy, done, err, result, lut_val, lut_div);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, bb; logic [5:0] res; logic er;
        do_op(6'd5, 8'd3, 6'd7, lat, res, er, bb);
        checks++;
        if (res !== 6'(ref_modexp(5, 3, 7))) begin
            errors++; $display("FAIL basic_result: got %0d expected %0d", res, ref_modexp(5, 3, 7));
        end
        checks++;
        if (lat !== ref_latency(8'd3, 7)) begin
            errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, ref_latency(8'd3, 7));
        end
        checks++;
        if (er !== 1'b0 || bb !== 0) begin
            errors++; $display("FAIL basic_err_busy: got err=%b busy_low_cycles=%0d expected 0/0", er, bb);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_after_done: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_rsa_round_trip();
        int lat, bb; logic [5:0] res; logic er;
        do_op(6'd8, 8'd3, 6'd55, lat, res, er, bb);
        checks++;
        if (res !== 6'(ref_modexp(8, 3, 55)) || lat !== ref_latency(8'd3, 55)) begin
            errors++; $display("FAIL rsa_encrypt: got %0d at %0d expected %0d at %0d",
                               res, lat, ref_modexp(8, 3, 55), ref_latency(8'd3, 55));
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL rsa_pulse1: got done=%b expected 0", done);
        end
        do_op(res, 8'd27, 6'd55, lat, res, er, bb);
        checks++;
        if (res !== 6'(ref_modexp(ref_modexp(8, 3, 55), 27, 55)) || lat !== ref_latency(8'd27, 55)) begin
            errors++; $display("FAIL rsa_decrypt: got %0d at %0d expected %0d at %0d",
                               res, lat, ref_modexp(ref_modexp(8, 3, 55), 27, 55), ref_latency(8'd27, 55));
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL rsa_pulse2: got done=%b expected 0", done);
        end
    endtask

    task automatic test_base_reduce();
        int lat, bb; logic [5:0] res; logic er;
        do_op(6'd63, 8'd255, 6'd61, lat, res, er, bb);
        checks++;
        if (res !== 6'(ref_modexp(63, 255, 61)) || lat !== ref_latency(8'd255, 61) || bb !== 0) begin
            errors++; $display("FAIL base_reduce: got %0d at %0d busy_low=%0d expected %0d at %0d",
                               res, lat, bb, ref_modexp(63, 255, 61), ref_latency(8'd255, 61));
        end
    endtask

    task automatic test_corners();
        int lat, bb; logic [5:0] res; logic er;
        logic [5:0] b; logic [EXP_W-1:0] e;
        b = 6'($urandom_range(0, 63)); e = EXP_W'($urandom_range(0, 255));
        do_op(b, e, 6'd0, lat, res, er, bb);
        checks++;
        if (lat !== 1 || res !== 6'd0 || er !== 1'b1) begin
            errors++; $display("FAIL mod_zero: got lat=%0d result=%0d err=%b expected 1/0/1", lat, res, er);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_hold: got err=%b expected 1", err);
        end
        do_op(6'd9, 8'd5, 6'd1, lat, res, er, bb);
        checks++;
        if (res !== 6'(ref_modexp(9, 5, 1)) || er !== 1'b0) begin
            errors++; $display("FAIL mod_one: got result=%0d err=%b expected %0d/0", res, er, ref_modexp(9, 5, 1));
        end
        do_op(6'd9, 8'd0, 6'd10, lat, res, er, bb);
        checks++;
        if (res !== 6'(ref_modexp(9, 0, 10)) || lat !== ref_latency(8'd0, 10)) begin
            errors++; $display("FAIL exp_zero: got %0d at %0d expected %0d at %0d",
                               res, lat, ref_modexp(9, 0, 10), ref_latency(8'd0, 10));
        end
        checks++;
        if (lut_val !== 12'd0 || lut_div !== 6'd10) begin
            errors++; $display("FAIL idle_lut: got val=%0d div=%0d expected 0/10", lut_val, lut_div);
        end
    endtask

    task automatic test_start_while_busy();
        int lat, dones; logic [5:0] res;
        base = 6'd5; exp_v = 8'd3; modulus = 6'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; dones = 0; res = '0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 5) begin
                start = 1'b1; base = 6'd40; exp_v = 8'd255; modulus = 6'd13;
            end
            if (n == 6) start = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (lat < 0) begin lat = n; res = result; end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (dones !== 1 || lat !== ref_latency(8'd3, 7) || res !== 6'(ref_modexp(5, 3, 7))) begin
            errors++; $display("FAIL busy_start: got dones=%0d lat=%0d result=%0d expected 1/%0d/%0d",
                               dones, lat, res, ref_latency(8'd3, 7), ref_modexp(5, 3, 7));
        end
    endtask

    task automatic test_back_to_back();
        int d[$]; int l;
        base = 6'd5; exp_v = 8'd3; modulus = 6'd7; start = 1'b1;
        l = ref_latency(8'd3, 7);
        @(posedge clk); #1;
        for (int n = 1; n <= 60; n++) begin
            if (done === 1'b1) d.push_back(n);
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (d.size() != 2) begin
            errors++; $display("FAIL held_start_count: got %0d pulses expected 2", d.size());
        end else if (d[0] != l || d[1] != 2 * l + 1) begin
            errors++; $display("FAIL held_start_timing: got %0d,%0d expected %0d,%0d", d[0], d[1], l, 2 * l + 1);
        end
        for (int n = 0; n < 60 && busy === 1'b1; n++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL held_start_drain: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bb, dones; logic [5:0] res; logic er;
        base = 6'd5; exp_v = 8'd3; modulus = 6'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, result, lut_val, lut_div} !== 27'd0) begin
            errors++; $display("FAIL async_reset: got busy=%b done=%b err=%b result=%0d val=%0d div=%0d expected all 0",
                               busy, done, err, result, lut_val, lut_div);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            if (done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        checks++;
        if (dones !== 0) begin
            errors++; $display("FAIL reset_no_done: got %0d pulses expected 0", dones);
        end
        do_op(6'd5, 8'd3, 6'd7, lat, res, er, bb);
        checks++;
        if (res !== 6'(ref_modexp(5, 3, 7)) || lat !== ref_latency(8'd3, 7)) begin
            errors++; $display("FAIL after_reset_op: got %0d at %0d expected %0d at %0d",
                               res, lat, ref_modexp(5, 3, 7), ref_latency(8'd3, 7));
        end
    endtask

    task automatic test_random();
        int lat, bb; logic [5:0] res, want; logic er;
        logic [5:0] b, m; logic [EXP_W-1:0] e;
        for (int i = 0; i < 10; i++) begin
            b = 6'($urandom_range(0, 63));
            e = EXP_W'($urandom_range(0, 255));
            m = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            exp_q.push_back(6'(ref_modexp(b, e, m)));
            do_op(b, e, m, lat, res, er, bb);
            want = exp_q.pop_front();
            checks++;
            if (res !== want || er !== (m == 6'd0) || lat !== ref_latency(e, m) || bb !== 0) begin
                errors++; $display("FAIL random_%0d: b=%0d e=%0d m=%0d got %0d err=%b lat=%0d expected %0d err=%b lat=%0d",
                                   i, b, e, m, res, er, lat, want, (m == 6'd0), ref_latency(e, m));
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_rsa_round_trip();
        test_base_reduce();
        test_corners();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
